// File: rtl/seq_decoder_pkg.sv
// ============================================================================
// Module : seq_decoder_pkg
// Brief  : Shared mode and state encodings for the sequential decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_decoder_pkg;

  localparam logic c_MODE_DECODE = 1'b0;
  localparam logic c_MODE_SCAN   = 1'b1;

  localparam int ST_W = 1;
  localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
  localparam logic [ST_W-1:0] ST_SCAN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_decoder_if.sv
// ============================================================================
// Module : seq_decoder_if
// Brief  : Control/select inputs and one-hot outputs of the sequential decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_decoder_if #(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
);
  logic               i_en;
  logic               i_mode;
  logic               i_start;
  logic [SEL_W-1:0]   i_sel;
  logic [NUM_OUT-1:0] o_d;
  logic               o_valid;
  logic               o_err;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_en, i_mode, i_start, i_sel,
    input  o_d, o_valid, o_err, o_busy, o_done
  );

  modport slave (
    input  i_en, i_mode, i_start, i_sel,
    output o_d, o_valid, o_err, o_busy, o_done
  );
endinterface

`default_nettype wire

// File: rtl/seq_decoder_core.sv
// ============================================================================
// Module : seq_decoder_core
// Brief  : Combinational select-to-one-hot decoder with an in-range flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_decoder_core #(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
) (
  input  wire logic [SEL_W-1:0]   i_sel,
  output logic      [NUM_OUT-1:0] o_onehot,
  output logic                    o_in_range
);

  // One extra bit keeps the compare valid when NUM_OUT == 2**SEL_W.
  assign o_in_range = ({1'b0, i_sel} < (SEL_W+1)'(NUM_OUT));

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_bit
    assign o_onehot[k] = (i_sel == SEL_W'(k));
  end

endmodule

`default_nettype wire

// File: rtl/seq_decoder.sv
// ============================================================================
// Module : seq_decoder
// Brief  : Registered one-hot decoder with a self-timed scan mode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
) (
  input wire logic       clk,
  input wire logic       rst_n,
  seq_decoder_if.slave   bus
);

  localparam logic [SEL_W-1:0] c_LAST = SEL_W'(NUM_OUT - 1);

  logic [ST_W-1:0]    r_state;
  logic [SEL_W-1:0]   r_cnt;
  logic [NUM_OUT-1:0] r_d;
  logic               r_valid;
  logic               r_err;
  logic               r_busy;
  logic               r_done;

  logic [SEL_W-1:0]   w_sel;
  logic [NUM_OUT-1:0] w_onehot;
  logic               w_in_range;
  logic               w_last;

  // The single decoder is shared: scan walks the counter, decode uses i_sel.
  assign w_sel  = (r_state == ST_SCAN) ? r_cnt : bus.i_sel;
  assign w_last = (r_cnt == c_LAST);

  seq_decoder_core #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_core (
    .i_sel      (w_sel),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_d     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_mode == c_MODE_SCAN) begin
            if (bus.i_start) begin
              r_state <= ST_SCAN;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end
          end else if (bus.i_en) begin
            if (w_in_range) begin
              r_d     <= w_onehot;
              r_valid <= 1'b1;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (bus.i_en) begin
            r_d     <= w_onehot;
            r_valid <= 1'b1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_d     = r_d;
  assign bus.o_valid = r_valid;
  assign bus.o_err   = r_err;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;

endmodule

`default_nettype wire
